video_timing: RTL and testbench
===============================

Name: video_timing

Overview:
- Generates the raster timing that drives the GPU pixel stages (foreground, background, and the output mixer).
- Produces the current and next-cycle pixel coordinates, VGA sync strobes, and frame/line markers.
- Runs on gpu_clk, one tick per output pixel.
- Vertical coordinates are in logical lines: each logical line spans LINE_REPEAT raw VGA lines.

Parameters:
- H_VISIBLE, 320, visible pixel ticks per raw line.
- H_FRONT, 8, horizontal front porch ticks.
- H_SYNC, 48, horizontal sync ticks.
- H_BACK, 24, horizontal back porch ticks (H_TOTAL = 400).
- V_VISIBLE, 480, visible raw lines.
- V_FRONT, 10, vertical front porch raw lines.
- V_SYNC, 2, vertical sync raw lines.
- V_BACK, 33, vertical back porch raw lines (V_TOTAL = 525).
- LINE_REPEAT, 2, raw lines per logical line; must be ≥ 1.

Ports:
- gpu_clk  input  1  pixel clock.
- rst  input  1  reset, asynchronous, active-high.
- enable_i  input  1  when 0, all counters and outputs hold.
- current_x_o  output  9  raw horizontal position this cycle, 0..H_TOTAL-1.
- current_y_o  output  9  logical line this cycle, 0..ceil(V_TOTAL/LINE_REPEAT)-1.
- next_x_o  output  9  value current_x_o will take on the next enabled cycle.
- next_y_o  output  9  value current_y_o will take on the next enabled cycle.
- hsync_o  output  1  active-low horizontal sync.
- vsync_o  output  1  active-low vertical sync.
- visible_o  output  1  current position is inside the visible window.
- vblank_o  output  1  current raw line ≥ V_VISIBLE.
- line_start_o  output  1  one-cycle pulse when current_x_o = 0.
- frame_start_o  output  1  one-cycle pulse when current_x_o = 0, raw line = 0.
- frame_count_o  output  8  completed-frame counter, wraps 255→0.

Behaviour:
State and counting:
- Internal state: hraw (9b), vraw (10b), rep (clog2(LINE_REPEAT)b), ly (9b), each kept as a "next" copy and a registered "current" copy.
- All outputs are registered, with no combinational path from any input to any output.
- Each enabled cycle, the current registers load the next registers, and the next registers advance by one tick.
- Horizontal: hraw increments and wraps at H_TOTAL-1 → 0.
- On an h-wrap:
  - vraw increments, wrapping V_TOTAL-1 → 0.
  - rep increments, wrapping LINE_REPEAT-1 → 0.
  - ly increments when rep wraps.
  - On a vraw wrap, rep and ly are forced to 0, even for a partial final logical line.
- ly is produced by counting only; no divider is used.

Decodes (all taken from the "current" copy):
- hsync_o = 0 iff H_VISIBLE+H_FRONT ≤ hraw < H_VISIBLE+H_FRONT+H_SYNC.
- vsync_o = 0 iff V_VISIBLE+V_FRONT ≤ vraw < V_VISIBLE+V_FRONT+V_SYNC.
- visible_o = (hraw < H_VISIBLE) && (vraw < V_VISIBLE).
- vblank_o = (vraw ≥ V_VISIBLE).

Frame counter:
- frame_count_o increments in the same cycle that current wraps from (H_TOTAL-1, last raw line) to (0, 0).
- frame_start_o is asserted in that same cycle.

Reset (asynchronous, dominates enable_i):
- Current copy at hraw=0, vraw=0, rep=0, ly=0.
- Next copy at hraw=1, vraw=0, ly=0.
- current_x_o=0, current_y_o=0, next_x_o=1, next_y_o=0.
- hsync_o=1, vsync_o=1, visible_o=1, vblank_o=0.
- line_start_o=1, frame_start_o=1, frame_count_o=0.
- The first post-reset cycle is therefore a valid frame start.
- Reset mid-line or mid-frame abandons the frame; no partial-frame count is recorded.

Enable:
- With enable_i=0, every register holds, including the pulse outputs.
- With enable_i=1, counting resumes with no skipped or repeated positions.

Invariant:
- next_x_o/next_y_o always equal the current_x_o/current_y_o of the following enabled cycle, including across line and frame wraps.

Width rules:
- Elaboration fails with $error if any of these hold: H_TOTAL > 512, V_TOTAL > 1024, LINE_REPEAT < 1, or ceil(V_TOTAL/LINE_REPEAT) > 512.

Test Plan:
- Release reset, enable_i=1 → cycle 0 shows current (0,0), next (1,0), line_start_o=1, frame_start_o=1; cycle 1 shows current (1,0), both pulses 0.
- Run to hraw 399 on raw line 0 → next_x_o=0, next_y_o=0 (rep 0→1); on raw line 1 at hraw 399 → next_y_o=1; current_y_o becomes 1 at raw line 2, x=0.
- Sweep one line → hsync_o falls at current_x_o=328, stays 0 through 375, returns to 1 at 376; visible_o drops at x=320.
- Sweep one frame → vblank_o rises at raw line 480; vsync_o=0 on raw lines 490–491 only; at (399, raw 524, current_y_o=262) next is (0,0); frame_count_o goes 0→1 with frame_start_o=1.
- Hold enable_i=0 for 10 cycles at x=100 → all outputs frozen; re-enable → x=101 follows with no gap.
- Assert rst asynchronously at (200, raw 300) between clock edges → outputs reach reset values immediately; frame_count_o=0 after release.

Source files
------------

// File: rtl/video_timing.sv
// Raster timing generator: current/next pixel coordinates, VGA syncs and frame markers.
// One tick per output pixel; vertical coordinates count logical lines of LINE_REPEAT raw lines.
module video_timing #(
    parameter int H_VISIBLE   = 320,
    parameter int H_FRONT     = 8,
    parameter int H_SYNC      = 48,
    parameter int H_BACK      = 24,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LINE_REPEAT = 2
) (
    input  logic       gpu_clk,
    input  logic       rst,
    input  logic       enable_i,
    output logic [8:0] current_x_o,
    output logic [8:0] current_y_o,
    output logic [8:0] next_x_o,
    output logic [8:0] next_y_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic       vblank_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_count_o
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int LY_TOTAL = (LINE_REPEAT < 1) ? V_TOTAL
                            : (V_TOTAL + LINE_REPEAT - 1) / LINE_REPEAT;
    localparam int REP_W    = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    localparam logic [8:0]       H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_REPEAT - 1);

    if (H_TOTAL > 512) begin : g_bad_h_total
        $error("video_timing: H_TOTAL exceeds 512");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("video_timing: V_TOTAL exceeds 1024");
    end
    if (LINE_REPEAT < 1) begin : g_bad_repeat
        $error("video_timing: LINE_REPEAT must be at least 1");
    end
    if (LY_TOTAL > 512) begin : g_bad_ly_total
        $error("video_timing: logical line count exceeds 512");
    end

    // "next" copy of the raster position, one enabled tick ahead of the outputs
    logic [8:0]       nxt_h_reg;
    logic [9:0]       nxt_v_reg;
    logic [REP_W-1:0] nxt_rep_reg;
    logic [8:0]       nxt_ly_reg;

    logic [8:0]       cur_h_reg;
    logic [9:0]       cur_v_reg;
    logic [8:0]       cur_ly_reg;

    logic [8:0]       adv_h;
    logic [9:0]       adv_v;
    logic [REP_W-1:0] adv_rep;
    logic [8:0]       adv_ly;

    logic             hsync_reg;
    logic             vsync_reg;
    logic             visible_reg;
    logic             vblank_reg;
    logic             line_start_reg;
    logic             frame_start_reg;
    logic [7:0]       frame_count_reg;

    logic             nxt_line_start;
    logic             nxt_frame_start;

    always_comb begin
        adv_h   = nxt_h_reg + 9'd1;
        adv_v   = nxt_v_reg;
        adv_rep = nxt_rep_reg;
        adv_ly  = nxt_ly_reg;
        if (nxt_h_reg == H_LAST) begin
            adv_h = '0;
            if (nxt_v_reg == V_LAST) begin
                // a partial final logical line is abandoned at the frame wrap
                adv_v   = '0;
                adv_rep = '0;
                adv_ly  = '0;
            end else begin
                adv_v = nxt_v_reg + 10'd1;
                if (nxt_rep_reg == REP_LAST) begin
                    adv_rep = '0;
                    adv_ly  = nxt_ly_reg + 9'd1;
                end else begin
                    adv_rep = nxt_rep_reg + REP_W'(1);
                end
            end
        end
    end

    assign nxt_line_start  = (nxt_h_reg == 9'd0);
    assign nxt_frame_start = nxt_line_start && (nxt_v_reg == 10'd0);

    // Decodes are computed from the next copy so they land in step with the current copy.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            nxt_h_reg       <= 9'd1;
            nxt_v_reg       <= '0;
            nxt_rep_reg     <= '0;
            nxt_ly_reg      <= '0;
            cur_h_reg       <= '0;
            cur_v_reg       <= '0;
            cur_ly_reg      <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            visible_reg     <= 1'b1;
            vblank_reg      <= 1'b0;
            line_start_reg  <= 1'b1;
            frame_start_reg <= 1'b1;
            frame_count_reg <= '0;
        end else if (enable_i) begin
            cur_h_reg       <= nxt_h_reg;
            cur_v_reg       <= nxt_v_reg;
            cur_ly_reg      <= nxt_ly_reg;
            nxt_h_reg       <= adv_h;
            nxt_v_reg       <= adv_v;
            nxt_rep_reg     <= adv_rep;
            nxt_ly_reg      <= adv_ly;
            hsync_reg       <= !((32'(nxt_h_reg) >= HS_START) && (32'(nxt_h_reg) < HS_END));
            vsync_reg       <= !((32'(nxt_v_reg) >= VS_START) && (32'(nxt_v_reg) < VS_END));
            visible_reg     <= (32'(nxt_h_reg) < H_VISIBLE) && (32'(nxt_v_reg) < V_VISIBLE);
            vblank_reg      <= (32'(nxt_v_reg) >= V_VISIBLE);
            line_start_reg  <= nxt_line_start;
            frame_start_reg <= nxt_frame_start;
            if (nxt_frame_start) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
        end
    end

    assign current_x_o   = cur_h_reg;
    assign current_y_o   = cur_ly_reg;
    assign next_x_o      = nxt_h_reg;
    assign next_y_o      = nxt_ly_reg;
    assign hsync_o       = hsync_reg;
    assign vsync_o       = vsync_reg;
    assign visible_o     = visible_reg;
    assign vblank_o      = vblank_reg;
    assign line_start_o  = line_start_reg;
    assign frame_start_o = frame_start_reg;
    assign frame_count_o = frame_count_reg;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: startup table, scoreboarded frame sweeps,
// enable hold and asynchronous mid-frame reset. Vertical timing is shortened to keep runs brief.
module tb_video_timing;

    localparam int HT  = 400;
    localparam int HV  = 320;
    localparam int HS0 = 328;
    localparam int HS1 = 376;
    localparam int VV  = 20;
    localparam int VS0 = 23;
    localparam int VS1 = 25;
    localparam int VT  = 27;
    localparam int LR  = 2;

    logic       gpu_clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic [8:0] current_x_o;
    logic [8:0] current_y_o;
    logic [8:0] next_x_o;
    logic [8:0] next_y_o;
    logic       hsync_o;
    logic       vsync_o;
    logic       visible_o;
    logic       vblank_o;
    logic       line_start_o;
    logic       frame_start_o;
    logic [7:0] frame_count_o;

    video_timing #(
        .V_VISIBLE   (VV),
        .V_FRONT     (VS0 - VV),
        .V_SYNC      (VS1 - VS0),
        .V_BACK      (VT - VS1),
        .LINE_REPEAT (LR)
    ) dut (
        .gpu_clk       (gpu_clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .current_x_o   (current_x_o),
        .current_y_o   (current_y_o),
        .next_x_o      (next_x_o),
        .next_y_o      (next_y_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .visible_o     (visible_o),
        .vblank_o      (vblank_o),
        .line_start_o  (line_start_o),
        .frame_start_o (frame_start_o),
        .frame_count_o (frame_count_o)
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct {
        int x; int y; int nx; int ny;
        int hs; int vs; int vis; int vb;
        int ls; int fs; int fc;
    } exp_t;

    typedef struct {
        logic en; int x; int nx; int ls; int fs;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[6];
    int   total = 0;
    int   bad = 0;
    int   mx = 0;
    int   mv = 0;
    int   fc = 0;
    bit   reached;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (model x=%0d raw_y=%0d)", name, act, exp, mx, mv);
        end
    endtask

    // Reference raster: raw position counters, logical line derived by division.
    function automatic exp_t model_exp();
        exp_t e;
        int nv;
        nv    = (mx == HT - 1) ? (mv + 1) % VT : mv;
        e.x   = mx;
        e.y   = mv / LR;
        e.nx  = (mx + 1) % HT;
        e.ny  = nv / LR;
        e.hs  = (mx >= HS0 && mx < HS1) ? 0 : 1;
        e.vs  = (mv >= VS0 && mv < VS1) ? 0 : 1;
        e.vis = (mx < HV && mv < VV) ? 1 : 0;
        e.vb  = (mv >= VV) ? 1 : 0;
        e.ls  = (mx == 0) ? 1 : 0;
        e.fs  = (mx == 0 && mv == 0) ? 1 : 0;
        e.fc  = fc;
        return e;
    endfunction

    task automatic model_step();
        mx++;
        if (mx == HT) begin
            mx = 0;
            mv = (mv + 1) % VT;
        end
        if (mx == 0 && mv == 0) fc = (fc + 1) % 256;
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            e = sb_q.pop_front();
            chk("current_x", int'(current_x_o), e.x);
            chk("current_y", int'(current_y_o), e.y);
            chk("next_x", int'(next_x_o), e.nx);
            chk("next_y", int'(next_y_o), e.ny);
            chk("hsync", int'(hsync_o), e.hs);
            chk("vsync", int'(vsync_o), e.vs);
            chk("visible", int'(visible_o), e.vis);
            chk("vblank", int'(vblank_o), e.vb);
            chk("line_start", int'(line_start_o), e.ls);
            chk("frame_start", int'(frame_start_o), e.fs);
            chk("frame_count", int'(frame_count_o), e.fc);
        end
    endtask

    // Called on a negedge: drive, clock once, check at the following negedge.
    task automatic cycle(input logic en);
        enable_i = en;
        @(posedge gpu_clk);
        if (en) model_step();
        sb_q.push_back(model_exp());
        @(negedge gpu_clk);
        compare_pop();
    endtask

    task automatic run_until(input int tx, input int tv, input int bound, input bit stalls);
        reached = 1'b0;
        for (int i = 0; i < bound; i++) begin
            cycle(stalls ? ($urandom_range(0, 31) != 0) : 1'b1);
            if (mx == tx && mv == tv) begin
                reached = 1'b1;
                break;
            end
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL reach_target: got x=%0d raw_y=%0d required x=%0d raw_y=%0d", mx, mv, tx, tv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{en: 1'b1, x: 1, nx: 2, ls: 0, fs: 0};
        tbl[1] = '{en: 1'b0, x: 1, nx: 2, ls: 0, fs: 0};
        tbl[2] = '{en: 1'b0, x: 1, nx: 2, ls: 0, fs: 0};
        tbl[3] = '{en: 1'b1, x: 2, nx: 3, ls: 0, fs: 0};
        tbl[4] = '{en: 1'b1, x: 3, nx: 4, ls: 0, fs: 0};
        tbl[5] = '{en: 1'b0, x: 3, nx: 4, ls: 0, fs: 0};

        rst      = 1'b1;
        enable_i = 1'b1;
        @(negedge gpu_clk);
        @(negedge gpu_clk);
        sb_q.push_back(model_exp());
        compare_pop();
        rst = 1'b0;
        #1;
        sb_q.push_back(model_exp());
        compare_pop();

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].en);
            chk("tbl_x", int'(current_x_o), tbl[i].x);
            chk("tbl_next_x", int'(next_x_o), tbl[i].nx);
            chk("tbl_line_start", int'(line_start_o), tbl[i].ls);
            chk("tbl_frame_start", int'(frame_start_o), tbl[i].fs);
        end

        // Hold at x=100 for ten cycles, then resume.
        run_until(100, 3, 3000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            chk("hold_x", int'(current_x_o), 100);
        end
        cycle(1'b1);
        chk("resume_x", int'(current_x_o), 101);

        // Two full frames with random stalls, including the short final logical line.
        for (int f = 1; f <= 2; f++) begin
            run_until(0, 0, 14000, 1'b1);
            chk("frame_count_wrap", int'(frame_count_o), f);
            chk("frame_start_wrap", int'(frame_start_o), 1);
            chk("current_y_wrap", int'(current_y_o), 0);
        end

        // Asynchronous reset between edges in the middle of a frame.
        run_until(200, 5, 3000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        mx = 0;
        mv = 0;
        fc = 0;
        sb_q.push_back(model_exp());
        compare_pop();
        chk("async_rst_fc", int'(frame_count_o), 0);
        @(negedge gpu_clk);
        sb_q.push_back(model_exp());
        compare_pop();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) cycle(1'b1);
        chk("post_rst_x", int'(current_x_o), 50);
        chk("post_rst_fc", int'(frame_count_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
